// File: rtl/control_buscaminas.sv
// Minesweeper game sequencer for an 8x8 board.
// Runs the bomb placer through its reset/done handshake, snapshots the bomb map,
// fills in neighbour counts one cell per cycle, then plays reveal/flag commands
// until the player wins or hits a bomb.
module control_buscaminas #(
  parameter logic [3:0] BOMBA = 4'hF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            numero_bombas,
  output logic                  place_reset,
  input  logic                  place_busy,
  input  logic [7:0][7:0][3:0]  matriz_in,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_flag,
  input  logic [2:0]            cmd_x,
  input  logic [2:0]            cmd_y,
  output logic [7:0][7:0][3:0]  tablero,
  output logic [63:0]           revelado,
  output logic [63:0]           bandera,
  output logic [2:0]            estado,
  output logic                  reveal_valid,
  output logic [3:0]            reveal_value
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLACING  = 3'd1,
    COUNTING = 3'd2,
    PLAYING  = 3'd3,
    WON      = 3'd4,
    LOST     = 3'd5
  } estado_t;

  estado_t               estado_q, estado_d;
  logic                  place_reset_q, place_reset_d;
  logic [7:0][7:0][3:0]  tablero_q, tablero_d;
  logic [63:0]           revelado_q, revelado_d;
  logic [63:0]           bandera_q, bandera_d;
  logic                  reveal_valid_q, reveal_valid_d;
  logic [3:0]            reveal_value_q, reveal_value_d;
  logic [63:0]           bombas_q, bombas_d;     // snapshot, bit x*8+y
  logic [5:0]            nbombas_q, nbombas_d;   // latched bomb count
  logic [5:0]            idx_q, idx_d;           // counting cursor
  logic [1:0]            settle_q, settle_d;     // placer busy blanking
  logic [6:0]            reveladas_q, reveladas_d; // safe cells revealed

  logic [2:0]            cx, cy;
  logic [9:0][9:0]       pad;
  logic [3:0]            vecinos;
  logic [5:0]            k;

  assign cx = idx_q[5:3];
  assign cy = idx_q[2:0];
  assign k  = {cmd_x, cmd_y};

  // Neighbour count for the cursor cell; a zero border around the map removes edge cases.
  always_comb begin
    pad = '0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        pad[x+1][y+1] = bombas_q[x*8+y];
    vecinos = '0;
    for (int dx = 0; dx < 3; dx++)
      for (int dy = 0; dy < 3; dy++)
        if (!(dx == 1 && dy == 1))
          vecinos = vecinos + {3'b000, pad[cx+dx][cy+dy]};
  end

  // Next-state and next-output logic for the whole game sequence.
  always_comb begin
    estado_d       = estado_q;
    place_reset_d  = place_reset_q;
    tablero_d      = tablero_q;
    revelado_d     = revelado_q;
    bandera_d      = bandera_q;
    reveal_valid_d = 1'b0;
    reveal_value_d = reveal_value_q;
    bombas_d       = bombas_q;
    nbombas_d      = nbombas_q;
    idx_d          = idx_q;
    settle_d       = settle_q;
    reveladas_d    = reveladas_q;

    case (estado_q)
      IDLE, WON, LOST: begin
        if (estado_q == IDLE) place_reset_d = 1'b1;
        if (start) begin
          nbombas_d     = numero_bombas;
          tablero_d     = '0;
          revelado_d    = '0;
          bandera_d     = '0;
          reveladas_d   = '0;
          settle_d      = '0;
          place_reset_d = 1'b1;   // first PLACING cycle is the placer reset pulse
          estado_d      = PLACING;
        end
      end
      PLACING: begin
        if (place_reset_q) begin
          place_reset_d = 1'b0;
          settle_d      = 2'd2;   // busy is stale for two cycles after reset drops
        end else if (settle_q != 2'd0) begin
          settle_d = settle_q - 2'd1;
        end else if (!place_busy) begin
          for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
              bombas_d[x*8+y] = (matriz_in[x][y] == BOMBA);
          idx_d    = '0;
          estado_d = COUNTING;
        end
      end
      COUNTING: begin
        tablero_d[cx][cy] = bombas_q[idx_q] ? BOMBA : vecinos;
        idx_d = idx_q + 6'd1;
        if (idx_q == 6'd63) estado_d = PLAYING;
      end
      PLAYING: begin
        if (cmd_valid) begin
          if (cmd_flag) begin
            if (!revelado_q[k]) bandera_d[k] = ~bandera_q[k];
          end else if (!revelado_q[k] && !bandera_q[k]) begin
            revelado_d[k]  = 1'b1;
            reveal_valid_d = 1'b1;
            reveal_value_d = tablero_q[cmd_x][cmd_y];
            if (tablero_q[cmd_x][cmd_y] == BOMBA) begin
              estado_d = LOST;
            end else begin
              reveladas_d = reveladas_q + 7'd1;
              if (reveladas_d == 7'd64 - {1'b0, nbombas_q}) estado_d = WON;
            end
          end
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= IDLE;
      place_reset_q  <= 1'b1;
      tablero_q      <= '0;
      revelado_q     <= '0;
      bandera_q      <= '0;
      reveal_valid_q <= 1'b0;
      reveal_value_q <= '0;
      bombas_q       <= '0;
      nbombas_q      <= '0;
      idx_q          <= '0;
      settle_q       <= '0;
      reveladas_q    <= '0;
    end else begin
      estado_q       <= estado_d;
      place_reset_q  <= place_reset_d;
      tablero_q      <= tablero_d;
      revelado_q     <= revelado_d;
      bandera_q      <= bandera_d;
      reveal_valid_q <= reveal_valid_d;
      reveal_value_q <= reveal_value_d;
      bombas_q       <= bombas_d;
      nbombas_q      <= nbombas_d;
      idx_q          <= idx_d;
      settle_q       <= settle_d;
      reveladas_q    <= reveladas_d;
    end
  end

  assign estado       = estado_q;
  assign place_reset  = place_reset_q;
  assign tablero      = tablero_q;
  assign revelado     = revelado_q;
  assign bandera      = bandera_q;
  assign reveal_valid = reveal_valid_q;
  assign reveal_value = reveal_value_q;
  assign cmd_ready    = (estado_q == PLAYING);

endmodule

// File: tb/tb_control_buscaminas.sv
// Bench for control_buscaminas: stub placer, game-level reference model checked
// every cycle, plus directed literal expectations.
module tb_control_buscaminas;

  // Stub placer: busy low in the 5th PLACING cycle (1 reset cycle, then busy
  // drops 3 cycles after reset falls; the controller already listens by then).
  localparam int PLACE_CYC = 5;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [5:0]           numero_bombas = '0;
  logic                 place_reset;
  logic                 place_busy = 1'b1;
  logic [7:0][7:0][3:0] board = '0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic                 cmd_flag = 1'b0;
  logic [2:0]           cmd_x = '0;
  logic [2:0]           cmd_y = '0;
  logic [7:0][7:0][3:0] tablero;
  logic [63:0]          revelado;
  logic [63:0]          bandera;
  logic [2:0]           estado;
  logic                 reveal_valid;
  logic [3:0]           reveal_value;

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  control_buscaminas #(.BOMBA(4'hF)) dut (
    .clock(clock), .reset(reset), .start(start), .numero_bombas(numero_bombas),
    .place_reset(place_reset), .place_busy(place_busy), .matriz_in(board),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_flag(cmd_flag),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .tablero(tablero), .revelado(revelado),
    .bandera(bandera), .estado(estado), .reveal_valid(reveal_valid),
    .reveal_value(reveal_value)
  );

  always #5 clock = ~clock;

  logic [2:0] stub_cnt = '0;
  always @(posedge clock) begin
    if (place_reset) begin
      stub_cnt   <= '0;
      place_busy <= 1'b1;
    end else if (stub_cnt != 3'd3) begin
      stub_cnt   <= stub_cnt + 3'd1;
      place_busy <= (stub_cnt + 3'd1 != 3'd3);
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference counts straight from the rules: bomb, or bombs among in-range neighbours.
  function automatic logic [7:0][7:0][3:0] full_board(input logic [7:0][7:0][3:0] b);
    logic [7:0][7:0][3:0] r;
    int n;
    r = '0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        if (b[x][y] == 4'hF) r[x][y] = 4'hF;
        else begin
          n = 0;
          for (int dx = -1; dx <= 1; dx++)
            for (int dy = -1; dy <= 1; dy++)
              if ((dx != 0 || dy != 0) && x+dx >= 0 && x+dx < 8 && y+dy >= 0 && y+dy < 8)
                if (b[x+dx][y+dy] == 4'hF) n++;
          r[x][y] = 4'(n);
        end
      end
    return r;
  endfunction

  // Game-level model.
  int                   m_state = 0;
  int                   m_pc = 0;
  int                   m_nb = 0;
  int                   m_safe = 0;
  logic [5:0]           m_ci = '0;
  logic [63:0]          m_rev = '0;
  logic [63:0]          m_flag = '0;
  logic [7:0][7:0][3:0] m_tab = '0;
  logic [7:0][7:0][3:0] m_full = '0;
  logic                 m_rv = 1'b0;
  logic [3:0]           m_rval = '0;

  always @(posedge clock) begin
    if (reset) begin
      m_state <= 0; m_pc <= 0; m_safe <= 0; m_ci <= '0;
      m_rev <= '0; m_flag <= '0; m_tab <= '0; m_rv <= 1'b0;
    end else begin
      m_rv <= 1'b0;
      case (m_state)
        0, 4, 5: if (start) begin
          m_nb <= int'(numero_bombas);
          m_tab <= '0; m_rev <= '0; m_flag <= '0; m_safe <= 0;
          m_state <= 1; m_pc <= 0;
        end
        1: if (m_pc + 1 == PLACE_CYC) begin
          m_state <= 2; m_ci <= '0; m_full <= full_board(board);
        end else m_pc <= m_pc + 1;
        2: begin
          m_tab[m_ci[5:3]][m_ci[2:0]] <= m_full[m_ci[5:3]][m_ci[2:0]];
          m_ci <= m_ci + 6'd1;
          if (m_ci == 6'd63) m_state <= 3;
        end
        3: if (cmd_valid) begin
          if (cmd_flag) begin
            if (!m_rev[{cmd_x, cmd_y}]) m_flag[{cmd_x, cmd_y}] <= !m_flag[{cmd_x, cmd_y}];
          end else if (!m_rev[{cmd_x, cmd_y}] && !m_flag[{cmd_x, cmd_y}]) begin
            m_rev[{cmd_x, cmd_y}] <= 1'b1;
            m_rv <= 1'b1;
            m_rval <= m_tab[cmd_x][cmd_y];
            if (m_tab[cmd_x][cmd_y] == 4'hF) m_state <= 5;
            else begin
              m_safe <= m_safe + 1;
              if (m_safe + 1 == 64 - m_nb) m_state <= 4;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("estado", 256'(estado), 256'(m_state));
      chk("tablero", 256'(tablero), 256'(m_tab));
      chk("revelado", 256'(revelado), 256'(m_rev));
      chk("bandera", 256'(bandera), 256'(m_flag));
      chk("cmd_ready", 256'(cmd_ready), 256'(m_state == 3));
      chk("reveal_valid", 256'(reveal_valid), 256'(m_rv));
      if (m_rv) chk("reveal_value", 256'(reveal_value), 256'(m_rval));
      if (m_state <= 3)
        chk("place_reset", 256'(place_reset), 256'(m_state == 0 || (m_state == 1 && m_pc == 0)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("rst_estado", 256'(estado), 256'(0));
    chk("rst_tablero", 256'(tablero), 256'(0));
  endtask

  task automatic new_game(input logic [5:0] nb);
    int n1, n2;
    n1 = 0; n2 = 0;
    numero_bombas = nb;
    start = 1'b1; tick(1); start = 1'b0;
    for (int c = 0; c < 200 && estado != 3'd3; c++) begin
      if (estado == 3'd1) n1++;
      if (estado == 3'd2) n2++;
      tick(1);
    end
    chk("reach_playing", 256'(estado), 256'(3));
    chk("place_len", 256'(n1), 256'(PLACE_CYC));
    chk("count_len", 256'(n2), 256'(64));
  endtask

  task automatic cmd(input logic f, input int x, input int y);
    cmd_valid = 1'b1; cmd_flag = f; cmd_x = 3'(x); cmd_y = 3'(y);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    tick(2);
    chk_en = 1'b1;
    chk("rst_estado0", 256'(estado), 256'(0));
    chk("rst_place_reset", 256'(place_reset), 256'(1));
    chk("rst_tablero0", 256'(tablero), 256'(0));
    reset = 1'b0;
    tick(2);

    // Empty board, zero bombs.
    board = '0;
    new_game(6'd0);
    chk("empty_tablero", 256'(tablero), 256'(0));

    // Single bomb at [0][0]; flag/reveal rules; win.
    do_reset();
    board = '0; board[0][0] = 4'hF;
    new_game(6'd1);
    chk("b00_00", 256'(tablero[0][0]), 256'(4'hF));
    chk("b00_01", 256'(tablero[0][1]), 256'(1));
    chk("b00_10", 256'(tablero[1][0]), 256'(1));
    chk("b00_11", 256'(tablero[1][1]), 256'(1));
    chk("b00_22", 256'(tablero[2][2]), 256'(0));
    cmd(1'b1, 2, 2);
    chk("flag18", 256'(bandera[18]), 256'(1));
    cmd(1'b0, 2, 2);
    chk("flagged_no_pulse", 256'(reveal_valid), 256'(0));
    chk("flagged_no_rev", 256'(revelado[18]), 256'(0));
    cmd(1'b1, 2, 2);
    cmd(1'b0, 2, 2);
    chk("rev22_pulse", 256'(reveal_valid), 256'(1));
    chk("rev22_val", 256'(reveal_value), 256'(0));
    cmd(1'b0, 1, 1);
    chk("rev11_val", 256'(reveal_value), 256'(1));
    cmd(1'b1, 1, 1);
    chk("flag_on_revealed", 256'(bandera[9]), 256'(0));
    for (int k = 1; k < 63; k++) cmd(1'b0, k / 8, k % 8);
    chk("not_won_yet", 256'(estado), 256'(3));
    cmd(1'b0, 7, 7);
    chk("won", 256'(estado), 256'(4));
    chk("won_ready", 256'(cmd_ready), 256'(0));

    // Bombs at [3][3] and [7][7]; lose, refuse, restart, reset mid-count.
    do_reset();
    board = '0; board[3][3] = 4'hF; board[7][7] = 4'hF;
    new_game(6'd2);
    chk("b33_22", 256'(tablero[2][2]), 256'(1));
    chk("b33_44", 256'(tablero[4][4]), 256'(1));
    chk("b33_24", 256'(tablero[2][4]), 256'(1));
    chk("b33_32", 256'(tablero[3][2]), 256'(1));
    chk("b77_66", 256'(tablero[6][6]), 256'(1));
    chk("nowrap_00", 256'(tablero[0][0]), 256'(0));
    chk("nowrap_70", 256'(tablero[7][0]), 256'(0));
    chk("nowrap_07", 256'(tablero[0][7]), 256'(0));
    cmd(1'b0, 3, 3);
    chk("boom_pulse", 256'(reveal_valid), 256'(1));
    chk("boom_val", 256'(reveal_value), 256'(4'hF));
    chk("lost", 256'(estado), 256'(5));
    cmd_valid = 1'b1;
    chk("lost_ready", 256'(cmd_ready), 256'(0));
    cmd(1'b0, 5, 5);
    chk("lost_refused", 256'(revelado[45]), 256'(0));
    start = 1'b1; tick(1); start = 1'b0;
    chk("restart", 256'(estado), 256'(1));
    for (int c = 0; c < 50 && estado != 3'd2; c++) tick(1);
    chk("reach_counting", 256'(estado), 256'(2));
    tick(10);
    do_reset();

    // All eight neighbours of [4][4] are bombs.
    board = '0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if (dx != 0 || dy != 0) board[4+dx][4+dy] = 4'hF;
    new_game(6'd8);
    chk("eight", 256'(tablero[4][4]), 256'(8));
    chk("corner_55_nb", 256'(tablero[2][2]), 256'(1));
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
